// File: rtl/branch_redirect_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_if
//  Description : Bundle between EX/fetch and the branch redirect controller.
//                The slave modport is the controller; master is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_redirect_if #(
    parameter int CNT_W = 32
);
    // EX resolution
    logic             resolved_valid;
    logic             resolved_taken;
    logic [31:0]      resolved_target;
    logic [31:0]      branch_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ds_fetched;
    // Redirect handshake to fetch
    logic             redirect_valid;
    logic             redirect_ready;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             ex_stall;
    // BHT read port used by fetch
    logic [31:0]      lookup_pc;
    logic             lookup_taken;
    // Statistics
    logic [CNT_W-1:0] mispredict_cnt;

    modport slave (
        input  resolved_valid, resolved_taken, resolved_target, branch_pc,
        input  pred_taken, pred_target, ds_fetched, redirect_ready, lookup_pc,
        output redirect_valid, redirect_pc, flush, ex_stall, lookup_taken,
        output mispredict_cnt
    );

    modport master (
        output resolved_valid, resolved_taken, resolved_target, branch_pc,
        output pred_taken, pred_target, ds_fetched, redirect_ready, lookup_pc,
        input  redirect_valid, redirect_pc, flush, ex_stall, lookup_taken,
        input  mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_ctrl
//  Description : Detects branch mispredicts from EX, holds the corrected PC
//                until the delay slot is fetched, then issues a valid/ready
//                redirect to fetch. Owns the 2-bit BHT and a mispredict count.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    branch_redirect_if.slave   bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_DS  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic               r_ex_stall;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_bht [BHT_DEPTH];

    logic               w_mispredict;
    logic [31:0]        w_correct_pc;
    logic               w_sample;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [IDX_W-1:0]   w_lkp_idx;
    logic [1:0]         w_cur_ctr;
    logic               w_unused;

    // Resolution is only looked at while idle; in other states EX is stalled.
    assign w_sample     = bus.resolved_valid && (r_state == S_IDLE);
    assign w_mispredict = (bus.resolved_taken != bus.pred_taken) ||
                          (bus.resolved_taken && bus.pred_taken &&
                           (bus.resolved_target != bus.pred_target));
    assign w_correct_pc = bus.resolved_taken ? bus.resolved_target
                                             : (bus.branch_pc + 32'd8);

    assign w_upd_idx    = bus.branch_pc[IDX_W+1:2];
    assign w_lkp_idx    = bus.lookup_pc[IDX_W+1:2];
    assign w_cur_ctr    = r_bht[w_upd_idx];

    // PC bits outside the BHT index never influence the prediction.
    assign w_unused     = ^{bus.branch_pc[31:IDX_W+2], bus.branch_pc[1:0],
                            bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0]};

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.ex_stall       = r_ex_stall;
    assign bus.mispredict_cnt = r_cnt;
    // Flush coincides with the accepted redirect, not a cycle later.
    assign bus.flush          = r_redirect_valid && bus.redirect_ready;
    // Read before the write lands, so a same-cycle update is not visible yet.
    assign bus.lookup_taken   = r_bht[w_lkp_idx][1];

    // Redirect FSM: latch corrected PC, wait for the delay slot, hand off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_ex_stall       <= 1'b0;
            r_cnt            <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.resolved_valid && w_mispredict) begin
                        r_redirect_pc <= w_correct_pc;
                        r_cnt         <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_ex_stall    <= 1'b1;
                        if (bus.ds_fetched) begin
                            r_state          <= S_REDIRECT;
                            r_redirect_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_DS;
                        end
                    end
                end
                S_WAIT_DS: begin
                    if (bus.ds_fetched) begin
                        r_state          <= S_REDIRECT;
                        r_redirect_valid <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_state          <= S_IDLE;
                        r_redirect_valid <= 1'b0;
                        r_ex_stall       <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_ex_stall       <= 1'b0;
                end
            endcase
        end
    end

    // BHT: saturating 2-bit counters trained by every sampled resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_sample) begin
            if (bus.resolved_taken) begin
                if (w_cur_ctr != 2'b11) begin
                    r_bht[w_upd_idx] <= w_cur_ctr + 2'b01;
                end
            end else begin
                if (w_cur_ctr != 2'b00) begin
                    r_bht[w_upd_idx] <= w_cur_ctr - 2'b01;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_redirect_ctrl
//  Description : Self-checking bench for branch_redirect_ctrl: vector table,
//                redirect scoreboard, and hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;
    logic clk;
    logic rst;

    branch_redirect_if #(.CNT_W(32)) bus ();

    branch_redirect_ctrl #(.BHT_DEPTH(64), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        pred;
        logic [31:0] ptgt;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    int          n_tests;
    int          n_fail;
    int          model_cnt;
    logic [1:0]  bht_m [64];
    logic [31:0] sb_q [$];
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] idx(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        model_cnt = 0;
        sb_q.delete();
    endtask

    task automatic model_train(input logic [31:0] pc, input logic taken);
        if (taken && bht_m[idx(pc)] != 2'b11) bht_m[idx(pc)] = bht_m[idx(pc)] + 2'b01;
        if (!taken && bht_m[idx(pc)] != 2'b00) bht_m[idx(pc)] = bht_m[idx(pc)] - 2'b01;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; waits (bounded) for a redirect, checks it against
    // the scoreboard head, accepts it and checks the flush pulse.
    task automatic do_handshake(input string name);
        int n = 0;
        logic [31:0] exp_pc;
        while (!bus.redirect_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.redirect_valid) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            check({name, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            exp_pc = sb_q.pop_front();
            check({name, "_pc"}, bus.redirect_pc, exp_pc);
            bus.redirect_ready = 1'b1;
            #1;
            check({name, "_flush"}, bus.flush, 1'b1);
            @(negedge clk);
            bus.redirect_ready = 1'b0;
            check({name, "_valid_after"}, bus.redirect_valid, 1'b0);
            check({name, "_stall_after"}, bus.ex_stall, 1'b0);
            check({name, "_flush_after"}, bus.flush, 1'b0);
        end
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        @(negedge clk);
        bus.branch_pc       = v.pc;
        bus.resolved_taken  = v.taken;
        bus.resolved_target = v.tgt;
        bus.pred_taken      = v.pred;
        bus.pred_target     = v.ptgt;
        bus.ds_fetched      = 1'b1;
        bus.redirect_ready  = 1'b0;
        bus.lookup_pc       = v.pc;
        bus.resolved_valid  = 1'b1;
        #1;
        check({name, "_lookup_pre"}, bus.lookup_taken, bht_m[idx(v.pc)][1]);
        model_train(v.pc, v.taken);
        if (v.exp_redir) begin
            sb_q.push_back(v.exp_pc);
            model_cnt++;
        end
        @(negedge clk);
        bus.resolved_valid = 1'b0;
        check({name, "_valid"}, bus.redirect_valid, v.exp_redir);
        check({name, "_stall"}, bus.ex_stall, v.exp_redir);
        if (v.exp_redir) do_handshake(name);
        check({name, "_cnt"}, bus.mispredict_cnt, model_cnt);
        #1;
        check({name, "_lookup_post"}, bus.lookup_taken, bht_m[idx(v.pc)][1]);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 32'h0000_0200};
        vecs[1] = '{32'h0000_0100, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_0100, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0300};
        vecs[3] = '{32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1, 32'h0000_0004};
        vecs[6] = '{32'h0000_0200, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0208};
        vecs[7] = '{32'h0000_0080, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b1, 32'h0000_0010};

        n_tests = 0;
        n_fail  = 0;
        bus.resolved_valid  = 1'b0;
        bus.resolved_taken  = 1'b0;
        bus.resolved_target = 32'd0;
        bus.branch_pc       = 32'd0;
        bus.pred_taken      = 1'b0;
        bus.pred_target     = 32'd0;
        bus.ds_fetched      = 1'b1;
        bus.redirect_ready  = 1'b0;
        bus.lookup_pc       = 32'd0;

        // Reset state
        do_reset();
        check("rst_valid", bus.redirect_valid, 1'b0);
        check("rst_pc", bus.redirect_pc, 32'd0);
        check("rst_flush", bus.flush, 1'b0);
        check("rst_stall", bus.ex_stall, 1'b0);
        check("rst_cnt", bus.mispredict_cnt, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.lookup_pc = 32'h100 * i + 32'h4;
            #1;
            check("rst_lookup", bus.lookup_taken, 1'b0);
        end

        // Table of single-shot resolutions with the delay slot already fetched
        for (int i = 0; i < 8; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Mispredict while the delay slot is still outstanding, then back-pressure
        @(negedge clk);
        bus.branch_pc       = 32'h100;
        bus.resolved_taken  = 1'b0;
        bus.resolved_target = 32'h0;
        bus.pred_taken      = 1'b1;
        bus.pred_target     = 32'h500;
        bus.ds_fetched      = 1'b0;
        bus.resolved_valid  = 1'b1;
        model_train(32'h100, 1'b0);
        sb_q.push_back(32'h108);
        model_cnt++;
        @(negedge clk);
        bus.resolved_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wds_valid", bus.redirect_valid, 1'b0);
            check("wds_stall", bus.ex_stall, 1'b1);
            @(negedge clk);
        end
        bus.ds_fetched = 1'b1;
        @(negedge clk);
        check("wds_redir", bus.redirect_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.redirect_valid, 1'b1);
            check("hold_pc", bus.redirect_pc, sb_q[0]);
            check("hold_flush", bus.flush, 1'b0);
        end
        do_handshake("wds");
        check("wds_cnt", bus.mispredict_cnt, model_cnt);

        // BHT training from a fresh reset: three correct taken resolutions
        do_reset();
        bus.lookup_pc = 32'h100;
        #1;
        check("bht_init", bus.lookup_taken, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_vec("bht_train", '{32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0});
        end
        check("bht_sat", {30'd0, bht_m[idx(32'h100)]}, 32'd3);
        check("bht_cnt", bus.mispredict_cnt, 32'd0);

        // Reset asserted between clock edges while a redirect is pending
        @(negedge clk);
        bus.branch_pc       = 32'h100;
        bus.resolved_taken  = 1'b1;
        bus.resolved_target = 32'h500;
        bus.pred_taken      = 1'b0;
        bus.ds_fetched      = 1'b1;
        bus.resolved_valid  = 1'b1;
        @(negedge clk);
        bus.resolved_valid = 1'b0;
        check("arst_pre_valid", bus.redirect_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.redirect_valid, 1'b0);
        check("arst_stall", bus.ex_stall, 1'b0);
        check("arst_cnt", bus.mispredict_cnt, 32'd0);
        bus.lookup_pc = 32'h100;
        #1;
        check("arst_bht", bus.lookup_taken, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("arst_after_valid", bus.redirect_valid, 1'b0);
        check("arst_after_pc", bus.redirect_pc, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
